// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice plus a carry flop,
// stepped LSB first over WIDTH cycles, with a one-cycle done pulse on completion.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_r, a_d;
    logic [WIDTH-1:0] b_r, b_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             carry, carry_d;
    logic             busy_d, done_d, cout_d, ovf_d;

    // Full-adder slice on the current LSBs
    logic             s_bit, c_out, last_step;
    assign s_bit     = a_r[0] ^ b_r[0] ^ carry;
    assign c_out     = (a_r[0] & b_r[0]) | (a_r[0] & carry) | (b_r[0] & carry);
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            a_r   <= a_d;
            b_r   <= b_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            carry <= carry_d;
            busy  <= busy_d;
            done  <= done_d;
            sum   <= sum_d;
            cout  <= cout_d;
            ovf   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state;
        a_d     = a_r;
        b_d     = b_r;
        acc_d   = acc;
        cnt_d   = cnt;
        carry_d = carry;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum;
        cout_d  = cout;
        ovf_d   = ovf;

        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = {s_bit, acc[WIDTH-1:1]};
                a_d     = a_r >> 1;
                b_d     = b_r >> 1;
                carry_d = c_out;
                cnt_d   = cnt + CW'(1);
                busy_d  = 1'b1;
                // Incoming carry on the MSB step is the carry into the MSB
                if (last_step) begin
                    sum_d   = {s_bit, acc[WIDTH-1:1]};
                    cout_d  = c_out;
                    ovf_d   = carry ^ c_out;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic reference model compared
// every cycle, plus directed operations with hand-computed results.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = 4;
    localparam int          MOD   = 1 << WIDTH;
    localparam int          HALF  = 1 << (WIDTH - 1);

    logic             clk = 1'b0;
    logic             rst, start, sub, cin;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout, ovf;
    logic [WIDTH-1:0] sum;

    serial_add_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from plain integer sums
    function automatic void compute(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic ci, output logic [WIDTH-1:0] r,
                                    output logic co, output logic ov);
        int ux, uy, sx, sy, full, sres;
        ux = int'(x);
        uy = int'(y);
        sx = x[WIDTH-1] ? ux - MOD : ux;
        sy = y[WIDTH-1] ? uy - MOD : uy;
        if (s) begin
            full = ux + (MOD - 1 - uy) + 1;
            sres = sx - sy;
        end else begin
            full = ux + uy + int'(ci);
            sres = sx + sy + int'(ci);
        end
        r  = WIDTH'(full);
        co = (full >= MOD);
        ov = (sres > HALF - 1) || (sres < -HALF);
    endfunction

    logic             m_busy, m_done, m_cout, m_ovf, p_cout, p_ovf;
    logic [WIDTH-1:0] m_sum, p_sum;
    int               m_rem;

    // Cycle-level model: start accepted when not busy, result appears WIDTH edges later
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_rem = 0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                compute(sub, a, b, cin, p_sum, p_cout, p_ovf);
                m_rem  = WIDTH;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_done));
            check("model_sum",  32'(sum),  32'(m_sum));
            check("model_cout", 32'(cout), 32'(m_cout));
            check("model_ovf",  32'(ovf),  32'(m_ovf));
        end
    end

    // Wait (bounded) for done; cyc counts negedges since the start-accept edge
    task automatic wait_done(inout int cyc, inout int nb);
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) nb++;
        end
    endtask

    task automatic run_op(input string name, input logic s, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic ci, input logic [WIDTH-1:0] esum,
                          input logic eco, input logic eov);
        int cyc, nb;
        @(negedge clk);
        sub = s; a = x; b = y; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        nb  = (busy === 1'b1) ? 1 : 0;
        wait_done(cyc, nb);
        check({name, "_latency"}, 32'(cyc), 32'd9);
        check({name, "_busy_cycles"}, 32'(nb), 32'd8);
        check({name, "_sum"},  32'(sum),  32'(esum));
        check({name, "_cout"}, 32'(cout), 32'(eco));
        check({name, "_ovf"},  32'(ovf),  32'(eov));
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    initial begin
        int cyc, nb, nd;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        chk_en = 1'b1;
        rst = 1'b0;

        run_op("zero", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Back-to-back: start held across DONE, operands advanced mid-operation
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 8'd1; b = 8'd2; start = 1'b1;
        @(negedge clk);
        a = 8'd31; b = 8'd1;
        cyc = 1; nb = 0;
        wait_done(cyc, nb);
        check("b2b1_latency", 32'(cyc), 32'd9);
        check("b2b1_sum", 32'(sum), 32'd3);
        @(negedge clk);
        a = 8'd37; b = 8'd21;
        cyc = 1; nb = 0;
        wait_done(cyc, nb);
        check("b2b2_latency", 32'(cyc), 32'd9);
        check("b2b2_sum", 32'(sum), 32'd32);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nb = 0;
        wait_done(cyc, nb);
        check("b2b3_latency", 32'(cyc), 32'd9);
        check("b2b3_sum", 32'(sum), 32'd58);

        run_op("add_wrap", 1'b0, 8'd255, 8'd1, 1'b0, 8'd0,   1'b1, 1'b0);
        run_op("add_ovf",  1'b0, 8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);
        run_op("add_cin",  1'b0, 8'd0,   8'd0, 1'b1, 8'd1,   1'b0, 1'b0);
        run_op("sub_borrow", 1'b1, 8'd5,   8'd7, 1'b0, 8'd254, 1'b0, 1'b0);
        run_op("sub_pos",    1'b1, 8'd7,   8'd5, 1'b1, 8'd2,   1'b1, 1'b0);
        run_op("sub_ovf",    1'b1, 8'd128, 8'd1, 1'b0, 8'd127, 1'b1, 1'b1);

        // start and operand changes during SHIFT must be ignored
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 8'd37; b = 8'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin a = 8'd200; b = 8'd100; start = 1'b1; end
            if (cyc == 5) start = 1'b0;
        end
        check("ignore_latency", 32'(cyc), 32'd9);
        check("ignore_sum", 32'(sum), 32'd58);
        count_dones(20, nd);
        check("ignore_no_second_done", 32'(nd), 32'd0);

        // Reset abandons an operation in flight
        @(negedge clk);
        a = 8'd255; b = 8'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 3) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum",  32'(sum),  32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;
        count_dones(20, nd);
        check("midrst_no_done", 32'(nd), 32'd0);
        run_op("after_rst", 1'b0, 8'd1, 8'd2, 1'b0, 8'd3, 1'b0, 1'b0);

        // rst and start together: start is not accepted
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd9;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        count_dones(15, nd);
        check("rst_start_no_done", 32'(nd), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
